uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised serial receiver with an output FIFO. It deserialises asynchronous frames of configurable width, idle polarity and parity, and validates the start, parity and stop bits using 3-sample majority voting. Received words go into a first-word-fall-through FIFO together with per-word error flags. It is the drop-in successor receiver for the UART link, feeding the downstream message consumer through a ready/empty handshake.

## Interface
- DATA_BITS, 20: payload bits per frame, LSB first; 1..32.
- CLKS_PER_BIT, 16: clock cycles per serial bit; ≥4.
- PARITY_EN, 0: 1 = one parity bit follows the data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored if PARITY_EN=0.
- IDLE_LEVEL, 0: line idle/stop level; start bit = ~IDLE_LEVEL.
- FIFO_DEPTH, 4: output FIFO entries; power of two ≥2.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- serialIn  in  1  raw serial line, asynchronous to clock.
- rdEn  in  1  pop head word; ignored when empty.
- dataOut  out  DATA_BITS  head-of-FIFO payload; valid while !empty.
- frameErr  out  1  head word's stop bit was not IDLE_LEVEL.
- parityErr  out  1  head word failed its parity check (0 when PARITY_EN=0).
- empty  out  1  FIFO holds no words.
- full  out  1  FIFO holds FIFO_DEPTH words.
- overrun  out  1  one-cycle pulse: a completed word was dropped.

## Operation
- serialIn passes through a 2-FF synchronizer (reset value IDLE_LEVEL). The FSM sees only the synchronized value s.
- Bit timer tc counts 0..CLKS_PER_BIT-1. Let M = CLKS_PER_BIT/2 (integer division). Samples are taken at tc = M-1, M, M+1. The bit value is the majority of the three samples and is decided at tc = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when s = ~IDLE_LEVEL, go to START with tc = 0.
- START: at the decision point, if the majority is IDLE_LEVEL it is a glitch; return to IDLE, nothing recorded. Otherwise continue to the bit boundary and go to DATA with bit index 0.
- DATA: decide each bit, shift it in LSB first, advance at tc = CLKS_PER_BIT-1. After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: parityErr_w = XOR(data, parity bit) XOR PARITY_ODD. This is nonzero on mismatch.
- STOP: at the decision point, set frameErr_w = (majority != IDLE_LEVEL), push {parityErr_w, frameErr_w, data} and return to IDLE immediately. A new start edge during the second half of the stop bit is accepted.
- Words with errors are still pushed, flagged.
- FIFO: write pointer and read pointer are each log2(FIFO_DEPTH)+1 bits and wrap naturally. full and empty are derived from the pointers.
  - Push while full and no pop: the word is dropped, FIFO unchanged, overrun pulses.
  - Push and pop in the same cycle while full: both happen; no overrun.
  - Push and pop while empty: the pop is ignored; the push happens.
- Reset mid-frame: FSM returns to IDLE, FIFO is emptied, the partial word is discarded.

## Timing
- Reset values: dataOut=0, frameErr=0, parityErr=0, empty=1, full=0, overrun=0.
- Start detect latency is 2 cycles (synchronizer) after the serialIn transition.
- Push happens on the clock edge at the stop-bit decision point, tc = M+1. The cycle after that edge, empty=0 and dataOut/flags show the head word.
- From the first serialIn edge to empty falling is about (1 + DATA_BITS + PARITY_EN)·CLKS_PER_BIT + M + 4 cycles.
- rdEn takes effect at the clock edge. The next word appears the following cycle; if that pop empties the FIFO, empty=1 the following cycle.
- All outputs are registered or derived from registered state. There are no combinational paths from serialIn or rdEn to outputs.
- Sustained throughput is one word per frame time. No gaps are required between frames beyond one stop bit.

## Test plan
- Config DATA_BITS=8, CLKS_PER_BIT=16, IDLE_LEVEL=1, PARITY_EN=0: send 0xA5 with a valid stop bit -> empty falls, dataOut=0xA5, frameErr=0, parityErr=0. Pulse rdEn -> empty=1.
- Same config: 5-cycle low pulse on an idle line -> FSM returns to IDLE, empty stays 1, no push.
- PARITY_EN=1, even parity: send 0x03 with parity bit 1 -> parityErr=1, dataOut=0x03. Send 0x03 with parity bit 0 -> parityErr=0.
- Default config (DATA_BITS=20, IDLE_LEVEL=0): send 0x12345 with the stop bit forced to 1 -> dataOut=0x12345, frameErr=1.
- FIFO_DEPTH=4: send 5 back-to-back words 1..5 with rdEn=0 -> full=1 after word 4, one overrun pulse on word 5. Reads return 1,2,3,4. Repeat with rdEn asserted on the 5th push cycle -> no overrun, reads return 2,3,4,5.
- Assert reset during DATA bit 3, then send 0x5A -> after reset all outputs are at reset values, and the only word received is 0x5A.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled serial receiver with 3-sample majority voting that
// feeds a first-word-fall-through FIFO carrying per-word frame/parity flags.
module uart_rx_fifo #(
  parameter int DATA_BITS    = 20,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int IDLE_LEVEL   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serialIn,
  input  logic                 rdEn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 frameErr,
  output logic                 parityErr,
  output logic                 empty,
  output logic                 full,
  output logic                 overrun
);
  localparam int M  = CLKS_PER_BIT / 2;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);
  localparam logic ODD_BIT  = (PARITY_ODD != 0);
  localparam logic [TW-1:0] TC_LO   = TW'(M - 1);
  localparam logic [TW-1:0] TC_MID  = TW'(M);
  localparam logic [TW-1:0] TC_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] TC_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 sync_p0, sync_p1, s;
  state_t               state_q, state_d;
  logic [TW-1:0]        tc;
  logic [BW-1:0]        bit_idx;
  logic                 smp_lo, smp_mid, bit_val;
  logic                 decide, last_tc;
  logic                 push, shift_en, par_en;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [WW-1:0]        head;
  logic [AW:0]          wptr, rptr;
  logic                 do_push, do_pop;

  // stage p0/p1: two-flop synchronizer; the FSM only ever sees s
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= IDLE_BIT;
      sync_p1 <= IDLE_BIT;
    end else begin
      sync_p0 <= serialIn;
      sync_p1 <= sync_p0;
    end
  end
  assign s = sync_p1;

  assign decide  = (tc == TC_DEC);
  assign last_tc = (tc == TC_LAST);
  assign bit_val = maj3(smp_lo, smp_mid, s);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (s != IDLE_BIT) state_d = S_START;
      S_START:  if (decide && bit_val == IDLE_BIT) state_d = S_IDLE;
                else if (last_tc)                  state_d = S_DATA;
      S_DATA:   if (last_tc && bit_idx == BIT_LAST)
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (last_tc) state_d = S_STOP;
      S_STOP:   if (decide)  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    case (state_q)
      S_DATA:   shift_en = decide;
      S_PARITY: par_en   = decide;
      S_STOP:   push     = decide;
      default:  ;
    endcase
  end

  // Timer restarts on every state change so each bit is measured from its own edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tc      <= '0;
      bit_idx <= '0;
      par_err <= 1'b0;
    end else begin
      tc <= (state_q == S_IDLE || last_tc || state_d != state_q) ? '0 : tc + TW'(1);
      if (state_q != S_DATA) bit_idx <= '0;
      else if (last_tc)      bit_idx <= bit_idx + BW'(1);
      if (state_q == S_IDLE) par_err <= 1'b0;
      else if (par_en)       par_err <= (^shreg) ^ bit_val ^ ODD_BIT;
    end
  end

  always_ff @(posedge clock) begin
    if (tc == TC_LO)  smp_lo  <= s;
    if (tc == TC_MID) smp_mid <= s;
    if (shift_en) begin
      shreg              <= shreg >> 1;
      shreg[DATA_BITS-1] <= bit_val;
    end
  end

  // FIFO: extra pointer MSB distinguishes full from empty
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = rdEn && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
      overrun <= push && !do_push;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= {par_err, (bit_val != IDLE_BIT), shreg};
  end

  assign head      = mem[rptr[AW-1:0]];
  assign dataOut   = empty ? '0 : head[DATA_BITS-1:0];
  assign frameErr  = !empty && head[DATA_BITS];
  assign parityErr = !empty && head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: two instances (8-bit/idle-high/even parity
// and default 20-bit/idle-low/no parity) driven by a frame-level line model.
module tb_uart_rx_fifo;
  localparam int C     = 16;
  localparam int M     = C / 2;
  localparam int NA    = 8;
  localparam int NB    = 20;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        fe;
    logic        pe;
  } word_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    line;
  logic [1:0]    rd_en;
  logic [1:0]    rd_force;
  logic          rd_mon_a = 1'b0, rd_mon_b = 1'b0;
  logic          rd_a, rd_b;
  logic [NA-1:0] data_a;
  logic [NB-1:0] data_b;
  logic          fe_a, pe_a, empty_a, full_a, ovr_a;
  logic          fe_b, pe_b, empty_b, full_b, ovr_b;

  word_t q_a[$];
  word_t q_b[$];
  int    exp_ovr[2];
  int    ovr_cnt_a = 0, ovr_cnt_b = 0;
  int    n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  assign rd_a = rd_mon_a | rd_force[0];
  assign rd_b = rd_mon_b | rd_force[1];

  uart_rx_fifo #(.DATA_BITS(NA), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0),
                 .IDLE_LEVEL(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clock(clock), .reset(reset), .serialIn(line[0]), .rdEn(rd_a),
    .dataOut(data_a), .frameErr(fe_a), .parityErr(pe_a),
    .empty(empty_a), .full(full_a), .overrun(ovr_a));

  uart_rx_fifo #(.DATA_BITS(NB), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0),
                 .IDLE_LEVEL(0), .FIFO_DEPTH(DEPTH)) dut_b (
    .clock(clock), .reset(reset), .serialIn(line[1]), .rdEn(rd_b),
    .dataOut(data_b), .frameErr(fe_b), .parityErr(pe_b),
    .empty(empty_b), .full(full_b), .overrun(ovr_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic void qpush(input int d, input word_t w);
    if (d == 0) q_a.push_back(w);
    else        q_b.push_back(w);
  endfunction

  function automatic void qdrop(input int d);
    if (d == 0) void'(q_a.pop_front());
    else        void'(q_b.pop_front());
  endfunction

  function automatic void qclear(input int d);
    if (d == 0) q_a.delete();
    else        q_b.delete();
  endfunction

  // Monitors: pop the DUT whenever it shows a word and reading is enabled
  always @(negedge clock) begin : mon_a
    word_t w;
    if (ovr_a) ovr_cnt_a++;
    rd_mon_a = 1'b0;
    if (!reset && rd_en[0] && !empty_a) begin
      if (q_a.size() == 0) chk("spurious_word_a", 32'(data_a), 32'hFFFF_FFFF);
      else begin
        w = q_a.pop_front();
        chk("data_a", 32'(data_a), w.data);
        chk("frameErr_a", 32'(fe_a), 32'(w.fe));
        chk("parityErr_a", 32'(pe_a), 32'(w.pe));
      end
      rd_mon_a = 1'b1;
    end
  end

  always @(negedge clock) begin : mon_b
    word_t w;
    if (ovr_b) ovr_cnt_b++;
    rd_mon_b = 1'b0;
    if (!reset && rd_en[1] && !empty_b) begin
      if (q_b.size() == 0) chk("spurious_word_b", 32'(data_b), 32'hFFFF_FFFF);
      else begin
        w = q_b.pop_front();
        chk("data_b", 32'(data_b), w.data);
        chk("frameErr_b", 32'(fe_b), 32'(w.fe));
        chk("parityErr_b", 32'(pe_b), 32'(w.pe));
      end
      rd_mon_b = 1'b1;
    end
  end

  // Drive one frame on instance d, starting at a negedge; records the expected word
  task automatic send(input int d, input logic [31:0] data, input bit par_flip,
                      input bit bad_stop, input bit pop_at_push);
    int          n, pen, push_off;
    logic        idle, pbit, stop_lvl;
    logic [31:0] mask, dm;
    logic        bits[$];
    word_t       w;
    n        = (d == 0) ? NA : NB;
    pen      = (d == 0) ? 1 : 0;
    idle     = (d == 0) ? 1'b1 : 1'b0;
    mask     = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    dm       = data & mask;
    pbit     = (^dm) ^ par_flip;
    stop_lvl = bad_stop ? ~idle : idle;
    bits.push_back(~idle);
    for (int i = 0; i < n; i++) bits.push_back(dm[i]);
    if (pen != 0) bits.push_back(pbit);
    bits.push_back(stop_lvl);
    if (bad_stop) begin
      bits.push_back(idle);
      bits.push_back(idle);
    end
    w.data = dm;
    w.pe   = (pen != 0) ? ((^dm) ^ pbit) : 1'b0;
    w.fe   = (stop_lvl != idle);
    if (pop_at_push) qdrop(d);
    if (!rd_en[d] && qsize(d) >= DEPTH) exp_ovr[d]++;
    else                                qpush(d, w);
    // stop-bit decision edge counted from the first edge after the start bit
    push_off = 2 + C * (1 + n + pen) + M + 2;
    for (int cyc = 0; cyc < bits.size() * C; cyc++) begin
      line[d] = bits[cyc / C];
      if (pop_at_push) rd_force[d] = (cyc == push_off);
      @(negedge clock);
    end
    rd_force[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int i;
    i = 0;
    while (qsize(d) != 0 && i < 2000) begin
      @(negedge clock);
      i++;
    end
    repeat (3) @(negedge clock);
    chk($sformatf("drain_pending_%0d", d), 32'(qsize(d)), 32'd0);
    chk($sformatf("drain_empty_%0d", d), 32'((d == 0) ? empty_a : empty_b), 32'd1);
    qclear(d);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_empty_a"}, 32'(empty_a), 32'd1);
    chk({tag, "_full_a"}, 32'(full_a), 32'd0);
    chk({tag, "_ovr_a"}, 32'(ovr_a), 32'd0);
    chk({tag, "_data_a"}, 32'(data_a), 32'd0);
    chk({tag, "_fe_a"}, 32'(fe_a), 32'd0);
    chk({tag, "_pe_a"}, 32'(pe_a), 32'd0);
    chk({tag, "_empty_b"}, 32'(empty_b), 32'd1);
    chk({tag, "_full_b"}, 32'(full_b), 32'd0);
    chk({tag, "_ovr_b"}, 32'(ovr_b), 32'd0);
    chk({tag, "_data_b"}, 32'(data_b), 32'd0);
    chk({tag, "_fe_b"}, 32'(fe_b), 32'd0);
    chk({tag, "_pe_b"}, 32'(pe_b), 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    line       = 2'b01;
    rd_en      = 2'b11;
    rd_force   = 2'b00;
    exp_ovr[0] = 0;
    exp_ovr[1] = 0;
    reset      = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_vals("reset");
    @(negedge clock) reset = 1'b0;
    repeat (2) @(negedge clock);

    // Clean frame, then parity error and parity ok
    send(0, 32'hA5, 1'b0, 1'b0, 1'b0);
    drain(0);
    send(0, 32'h03, 1'b1, 1'b0, 1'b0);
    send(0, 32'h03, 1'b0, 1'b0, 1'b0);
    drain(0);

    // 5-cycle glitch on an idle-high line
    line[0] = 1'b0;
    repeat (5) @(negedge clock);
    line[0] = 1'b1;
    repeat (3 * C) @(negedge clock);
    chk("glitch_empty_a", 32'(empty_a), 32'd1);

    // Default config with a bad stop bit
    send(1, 32'h12345, 1'b0, 1'b1, 1'b0);
    drain(1);

    // Overflow without a pop
    rd_en[0] = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 32'(i), 1'b0, 1'b0, 1'b0);
    chk("full_after4", 32'(full_a), 32'd1);
    send(0, 32'd5, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    chk("overrun_count_a1", 32'(ovr_cnt_a), 32'(exp_ovr[0]));
    chk("full_after5", 32'(full_a), 32'd1);
    rd_en[0] = 1'b1;
    drain(0);
    chk("full_after_drain", 32'(full_a), 32'd0);

    // Overflow with a pop on the push edge
    rd_en[0] = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 32'(i), 1'b0, 1'b0, 1'b0);
    send(0, 32'd5, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    chk("overrun_count_a2", 32'(ovr_cnt_a), 32'(exp_ovr[0]));
    chk("full_after_pop_push", 32'(full_a), 32'd1);
    rd_en[0] = 1'b1;
    drain(0);

    // Reset in the middle of data bit 3 with a word already queued
    rd_en[1] = 1'b0;
    send(1, $urandom, 1'b0, 1'b0, 1'b0);
    chk("queued_before_reset", 32'(empty_b), 32'd0);
    line[1] = 1'b1;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      line[1] = 1'($urandom_range(0, 1));
      repeat (C) @(negedge clock);
    end
    line[1] = 1'b1;
    repeat (C / 2) @(negedge clock);
    reset   = 1'b1;
    line[1] = 1'b0;
    #1 reset_vals("midreset");
    qclear(1);
    ovr_cnt_a = 0;
    ovr_cnt_b = 0;
    exp_ovr[0] = 0;
    exp_ovr[1] = 0;
    repeat (3) @(negedge clock);
    reset    = 1'b0;
    rd_en[1] = 1'b1;
    repeat (2 * C) @(negedge clock);
    chk("after_reset_empty_b", 32'(empty_b), 32'd1);
    send(1, 32'h5A, 1'b0, 1'b0, 1'b0);
    drain(1);

    // Randomized frames on both configurations
    for (int k = 0; k < 6; k++)
      send(0, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
    drain(0);
    for (int k = 0; k < 4; k++)
      send(1, $urandom, 1'b0, ($urandom_range(0, 2) == 0), 1'b0);
    drain(1);
    chk("overrun_total_a", 32'(ovr_cnt_a), 32'(exp_ovr[0]));
    chk("overrun_total_b", 32'(ovr_cnt_b), 32'(exp_ovr[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
